sm_diff_reconstructor: RTL



---
 rtl/sm_diff_reconstructor_pkg.sv | 27 ++
 rtl/sm_diff_reconstructor_serial_fa_cell.sv | 30 +++
 rtl/sm_diff_reconstructor.sv | 110 +++++++++++
 3 files changed

// File: rtl/sm_diff_reconstructor_pkg.sv
// Shared types, limits and the arithmetic reference for the difference reconstructor.
package sm_diff_pkg;

    localparam int unsigned DEFAULT_WIDTH = 2;
    localparam int unsigned MAX_WIDTH     = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Plain-arithmetic reconstruction of a = b +/- mag; returns {range_err, a mod 2^width}.
    function automatic logic [MAX_WIDTH:0] ref_reconstruct(
        input logic                 sign,
        input logic [MAX_WIDTH-1:0] mag,
        input logic [MAX_WIDTH-1:0] b,
        input int unsigned          width
    );
        int full;
        int lim;
        lim  = 1 << width;
        full = sign ? (int'(b) - int'(mag)) : (int'(b) + int'(mag));
        return {((full < 0) || (full >= lim)), MAX_WIDTH'(full & (lim - 1))};
    endfunction

endpackage

// File: rtl/sm_diff_reconstructor_serial_fa_cell.sv
// One-bit serial full adder with a presettable carry flop.
module serial_fa_cell (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic preset,
    input  logic en,
    input  logic x,
    input  logic y,
    output logic sum_c,
    output logic carry
);

    logic carry_next_c;

    assign sum_c        = x ^ y ^ carry;
    assign carry_next_c = (x & y) | (carry & (x ^ y));

    // Carry is preset when a request starts and advances once per processed bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry <= 1'b0;
        end else if (start) begin
            carry <= preset;
        end else if (en) begin
            carry <= carry_next_c;
        end
    end

endmodule

// File: rtl/sm_diff_reconstructor.sv
// Rebuilds a from a sign/magnitude difference and b, bit-serially LSB first.
module sm_diff_reconstructor
    import sm_diff_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign,
    input  logic [WIDTH-1:0] mag,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic             range_err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic             in_ready_next;
    logic             out_valid_next;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] op_sr;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             carry;
    logic             sum_c;
    logic             final_cout_c;
    logic             accept_c;
    logic             shift_c;
    logic             last_bit_c;
    logic [WIDTH:0]   a_shift_c;

    assign accept_c     = in_valid && in_ready;
    assign shift_c      = (state == SHIFT);
    assign last_bit_c   = shift_c && (count == CW'(WIDTH - 1));
    assign a_shift_c    = {sum_c, a};
    // Carry out of the bit being added; on the last bit this decides range_err.
    assign final_cout_c = (b_sr[0] & op_sr[0]) | (carry & (b_sr[0] ^ op_sr[0]));

    serial_fa_cell u_fa (
        .clk    (clk),
        .rst    (rst),
        .start  (accept_c),
        .preset (sign),
        .en     (shift_c),
        .x      (b_sr[0]),
        .y      (op_sr[0]),
        .sum_c  (sum_c),
        .carry  (carry)
    );

    // State and handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= in_ready_next;
            out_valid <= out_valid_next;
        end
    end

    // Next state; handshake flags follow the state being entered.
    always_comb begin
        state_next     = state;
        in_ready_next  = 1'b0;
        out_valid_next = 1'b0;
        case (state)
            IDLE:    if (accept_c)   state_next = SHIFT;
            SHIFT:   if (last_bit_c) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        in_ready_next  = (state_next == IDLE);
        out_valid_next = (state_next == DONE);
    end

    // Operand capture, serial shifting and result/flag accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_sr      <= '0;
            op_sr     <= '0;
            a         <= '0;
            count     <= '0;
            sign_q    <= 1'b0;
            range_err <= 1'b0;
        end else if (accept_c) begin
            b_sr   <= b;
            op_sr  <= sign ? ~mag : mag;
            sign_q <= sign;
            count  <= '0;
        end else if (shift_c) begin
            b_sr  <= b_sr >> 1;
            op_sr <= op_sr >> 1;
            a     <= a_shift_c[WIDTH:1];
            count <= count + CW'(1);
            if (last_bit_c) begin
                range_err <= sign_q ^ final_cout_c;
            end
        end
    end

endmodule
